sdram_burst_arbiter: RTL and testbench

//  Schedules and time-shares the single SDRAM controller user port between two burst requesters.
//  The write channel is the camera frame-write path; the read channel is the video frame-read path.

---
 rtl/sdram_burst_arbiter_if.sv | 60 ++++++
 rtl/sdram_burst_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_arbiter_if.sv
`default_nettype none
// ==========================================================================
// Module  : sdram_burst_arbiter_if
// Purpose : requester, SDRAM-command and read-return signals of the arbiter
// Revision: 1.0
// ==========================================================================
interface sdram_burst_arbiter_if #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 21,
  parameter int BURST_BITS    = 10
);
  logic                       Sdr_init_done;
  logic                       Sdr_busy;
  logic                       wr_burst_req;
  logic [ADDR_BITS-1:0]       wr_burst_addr;
  logic [BURST_BITS:0]        wr_burst_len;
  logic                       wr_burst_ack;
  logic                       wr_data_req;
  logic [MEM_DATA_BITS-1:0]   wr_burst_data;
  logic                       wr_burst_finish;
  logic                       rd_burst_req;
  logic [ADDR_BITS-1:0]       rd_burst_addr;
  logic [BURST_BITS:0]        rd_burst_len;
  logic                       rd_urgent;
  logic                       rd_burst_ack;
  logic                       rd_data_valid;
  logic [MEM_DATA_BITS-1:0]   rd_burst_data;
  logic                       rd_burst_finish;
  logic                       App_wr_en;
  logic [ADDR_BITS-1:0]       App_wr_addr;
  logic [MEM_DATA_BITS-1:0]   App_wr_din;
  logic [MEM_DATA_BITS/8-1:0] App_wr_dm;
  logic                       App_rd_en;
  logic [ADDR_BITS-1:0]       App_rd_addr;
  logic                       Sdr_rd_en;
  logic [MEM_DATA_BITS-1:0]   Sdr_rd_dout;

  // arbiter view
  modport master (
    input  Sdr_init_done, Sdr_busy,
    input  wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
    output wr_burst_ack, wr_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_addr, rd_burst_len, rd_urgent,
    output rd_burst_ack, rd_data_valid, rd_burst_data, rd_burst_finish,
    output App_wr_en, App_wr_addr, App_wr_din, App_wr_dm, App_rd_en, App_rd_addr,
    input  Sdr_rd_en, Sdr_rd_dout
  );

  // requester / controller view
  modport slave (
    output Sdr_init_done, Sdr_busy,
    output wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
    input  wr_burst_ack, wr_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_addr, rd_burst_len, rd_urgent,
    input  rd_burst_ack, rd_data_valid, rd_burst_data, rd_burst_finish,
    input  App_wr_en, App_wr_addr, App_wr_din, App_wr_dm, App_rd_en, App_rd_addr,
    output Sdr_rd_en, Sdr_rd_dout
  );
endinterface
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// ==========================================================================
// Module  : sdram_burst_arbiter
// Purpose : grants whole write/read bursts to one SDRAM user port, expands them into word commands
// Revision: 1.0
// ==========================================================================
module sdram_burst_arbiter #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 21,
  parameter int BURST_BITS    = 10
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  sdram_burst_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam logic                GRANT_WR = 1'b0;
  localparam logic                GRANT_RD = 1'b1;
  localparam logic [BURST_BITS:0] CNT_ZERO = '0;
  localparam logic [BURST_BITS:0] CNT_ONE  = {{BURST_BITS{1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic [ADDR_BITS-1:0]       base_addr_q, base_addr_d;
  logic [BURST_BITS:0]        len_q, len_d;
  logic [BURST_BITS:0]        issue_cnt_q, issue_cnt_d;
  logic [BURST_BITS:0]        ret_cnt_q, ret_cnt_d;
  logic                       wr_burst_ack_q, wr_burst_ack_d;
  logic                       rd_burst_ack_q, rd_burst_ack_d;
  logic                       wr_burst_finish_q, wr_burst_finish_d;
  logic                       rd_burst_finish_q, rd_burst_finish_d;
  logic                       app_wr_en_q, app_wr_en_d;
  logic [ADDR_BITS-1:0]       app_wr_addr_q, app_wr_addr_d;
  logic [MEM_DATA_BITS-1:0]   app_wr_din_q, app_wr_din_d;
  logic                       app_rd_en_q, app_rd_en_d;
  logic [ADDR_BITS-1:0]       app_rd_addr_q, app_rd_addr_d;
  logic                       rd_data_valid_q, rd_data_valid_d;
  logic [MEM_DATA_BITS-1:0]   rd_burst_data_q, rd_burst_data_d;
  logic                       wr_data_req;

  logic                       cmd_slot;
  logic                       pick_rd;
  logic                       pick_wr;
  logic [BURST_BITS:0]        issue_nxt;
  logic [BURST_BITS:0]        ret_nxt;
  logic [ADDR_BITS-1:0]       cmd_addr;

  // The controller needs a cycle to raise Sdr_busy after a strobe, hence the one-cycle gap.
  assign cmd_slot  = !bus.Sdr_busy && !app_wr_en_q && !app_rd_en_q;
  assign issue_nxt = issue_cnt_q + CNT_ONE;
  assign ret_nxt   = ret_cnt_q + CNT_ONE;
  assign cmd_addr  = base_addr_q + ADDR_BITS'(issue_cnt_q);
  assign pick_rd   = bus.rd_burst_req &&
                     (bus.rd_urgent || !bus.wr_burst_req || (last_grant_q == GRANT_WR));
  assign pick_wr   = bus.wr_burst_req && !pick_rd;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    base_addr_d       = base_addr_q;
    len_d             = len_q;
    issue_cnt_d       = issue_cnt_q;
    ret_cnt_d         = ret_cnt_q;
    wr_burst_ack_d    = 1'b0;
    rd_burst_ack_d    = 1'b0;
    wr_burst_finish_d = 1'b0;
    rd_burst_finish_d = 1'b0;
    app_wr_en_d       = 1'b0;
    app_wr_addr_d     = app_wr_addr_q;
    app_wr_din_d      = app_wr_din_q;
    app_rd_en_d       = 1'b0;
    app_rd_addr_d     = app_rd_addr_q;
    rd_data_valid_d   = 1'b0;
    rd_burst_data_d   = rd_burst_data_q;
    wr_data_req       = 1'b0;

    case (state_q)
      IDLE: begin
        // A requester still sees its own ack this cycle; holding off avoids a double grant.
        if (bus.Sdr_init_done && !wr_burst_ack_q && !rd_burst_ack_q) begin
          if (pick_rd) begin
            base_addr_d    = bus.rd_burst_addr;
            len_d          = bus.rd_burst_len;
            issue_cnt_d    = CNT_ZERO;
            ret_cnt_d      = CNT_ZERO;
            rd_burst_ack_d = 1'b1;
            last_grant_d   = GRANT_RD;
            if (bus.rd_burst_len == CNT_ZERO) rd_burst_finish_d = 1'b1;
            else                              state_d           = RD_BURST;
          end else if (pick_wr) begin
            base_addr_d    = bus.wr_burst_addr;
            len_d          = bus.wr_burst_len;
            issue_cnt_d    = CNT_ZERO;
            ret_cnt_d      = CNT_ZERO;
            wr_burst_ack_d = 1'b1;
            last_grant_d   = GRANT_WR;
            if (bus.wr_burst_len == CNT_ZERO) wr_burst_finish_d = 1'b1;
            else                              state_d           = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        if (cmd_slot && (issue_cnt_q != len_q)) begin
          wr_data_req   = 1'b1;
          app_wr_en_d   = 1'b1;
          app_wr_addr_d = cmd_addr;
          app_wr_din_d  = bus.wr_burst_data;
          issue_cnt_d   = issue_nxt;
          if (issue_nxt == len_q) begin
            wr_burst_finish_d = 1'b1;
            state_d           = IDLE;
          end
        end
      end
      RD_BURST: begin
        if (cmd_slot && (issue_cnt_q != len_q)) begin
          app_rd_en_d   = 1'b1;
          app_rd_addr_d = cmd_addr;
          issue_cnt_d   = issue_nxt;
          if (issue_nxt == len_q) state_d = RD_DRAIN;
        end
      end
      default: ;
    endcase

    // Return path runs alongside issue so a return coincident with the last command is counted.
    if (((state_q == RD_BURST) || (state_q == RD_DRAIN)) && bus.Sdr_rd_en) begin
      rd_data_valid_d = 1'b1;
      rd_burst_data_d = bus.Sdr_rd_dout;
      ret_cnt_d       = ret_nxt;
      if (ret_nxt == len_q) begin
        rd_burst_finish_d = 1'b1;
        state_d           = IDLE;
      end
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      last_grant_q      <= GRANT_RD;
      base_addr_q       <= '0;
      len_q             <= '0;
      issue_cnt_q       <= '0;
      ret_cnt_q         <= '0;
      wr_burst_ack_q    <= 1'b0;
      rd_burst_ack_q    <= 1'b0;
      wr_burst_finish_q <= 1'b0;
      rd_burst_finish_q <= 1'b0;
      app_wr_en_q       <= 1'b0;
      app_wr_addr_q     <= '0;
      app_wr_din_q      <= '0;
      app_rd_en_q       <= 1'b0;
      app_rd_addr_q     <= '0;
      rd_data_valid_q   <= 1'b0;
      rd_burst_data_q   <= '0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      base_addr_q       <= base_addr_d;
      len_q             <= len_d;
      issue_cnt_q       <= issue_cnt_d;
      ret_cnt_q         <= ret_cnt_d;
      wr_burst_ack_q    <= wr_burst_ack_d;
      rd_burst_ack_q    <= rd_burst_ack_d;
      wr_burst_finish_q <= wr_burst_finish_d;
      rd_burst_finish_q <= rd_burst_finish_d;
      app_wr_en_q       <= app_wr_en_d;
      app_wr_addr_q     <= app_wr_addr_d;
      app_wr_din_q      <= app_wr_din_d;
      app_rd_en_q       <= app_rd_en_d;
      app_rd_addr_q     <= app_rd_addr_d;
      rd_data_valid_q   <= rd_data_valid_d;
      rd_burst_data_q   <= rd_burst_data_d;
    end
  end

  assign bus.wr_burst_ack    = wr_burst_ack_q;
  assign bus.wr_data_req     = wr_data_req;
  assign bus.wr_burst_finish = wr_burst_finish_q;
  assign bus.rd_burst_ack    = rd_burst_ack_q;
  assign bus.rd_data_valid   = rd_data_valid_q;
  assign bus.rd_burst_data   = rd_burst_data_q;
  assign bus.rd_burst_finish = rd_burst_finish_q;
  assign bus.App_wr_en       = app_wr_en_q;
  assign bus.App_wr_addr     = app_wr_addr_q;
  assign bus.App_wr_din      = app_wr_din_q;
  assign bus.App_wr_dm       = '0;
  assign bus.App_rd_en       = app_rd_en_q;
  assign bus.App_rd_addr     = app_rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// ==========================================================================
// Module  : tb_sdram_burst_arbiter
// Purpose : directed bursts against sdram_burst_arbiter with a queued expected-response scoreboard
// Revision: 1.0
// ==========================================================================
module tb_sdram_burst_arbiter;
  localparam int MEM_DATA_BITS = 32;
  localparam int ADDR_BITS     = 21;
  localparam int BURST_BITS    = 10;
  localparam int ACK_TIMEOUT   = 3000;
  localparam int DRAIN_TIMEOUT = 2000;

  typedef struct packed { logic is_rd; logic len0; } grant_t;
  typedef struct packed {
    logic [ADDR_BITS-1:0] addr; logic [MEM_DATA_BITS-1:0] data; logic fin; logic gap;
  } wr_exp_t;
  typedef struct packed { logic [MEM_DATA_BITS-1:0] data; logic fin; } rd_ret_t;
  typedef struct packed { logic [ADDR_BITS-1:0] addr; int due; } pend_t;

  logic mem_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ack_seen = 0;
  int   wr_exp_idx = 0;
  int   wr_pop_idx = 0;
  int   last_wr_cyc = 0;
  logic busy_prev = 1'b0;

  grant_t               grant_q[$];
  wr_exp_t              wr_q[$];
  logic [ADDR_BITS-1:0] rdcmd_q[$];
  rd_ret_t              rdret_q[$];
  pend_t                pend_q[$];

  always #5 mem_clk = ~mem_clk;
  always @(posedge mem_clk) cyc <= cyc + 1;

  sdram_burst_arbiter_if #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS),
                           .BURST_BITS(BURST_BITS)) bus ();

  sdram_burst_arbiter #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS),
                        .BURST_BITS(BURST_BITS)) dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .bus     (bus)
  );

  function automatic logic [MEM_DATA_BITS-1:0] wr_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [MEM_DATA_BITS-1:0] rd_word(input logic [ADDR_BITS-1:0] a);
    return {11'h5A5, a};
  endfunction

  task automatic push_wr(input logic [ADDR_BITS-1:0] addr, input int len, input logic gap);
    grant_t g; wr_exp_t e;
    g.is_rd = 1'b0; g.len0 = (len == 0); grant_q.push_back(g);
    for (int i = 0; i < len; i++) begin
      e.addr = addr + ADDR_BITS'(i);
      e.data = wr_word(wr_exp_idx);
      e.fin  = (i == len - 1);
      e.gap  = gap && (i > 0);
      wr_exp_idx++;
      wr_q.push_back(e);
    end
  endtask

  task automatic push_rd(input logic [ADDR_BITS-1:0] addr, input int len);
    grant_t g; rd_ret_t r; logic [ADDR_BITS-1:0] a;
    g.is_rd = 1'b1; g.len0 = (len == 0); grant_q.push_back(g);
    for (int i = 0; i < len; i++) begin
      a = addr + ADDR_BITS'(i);
      rdcmd_q.push_back(a);
      r.data = rd_word(a); r.fin = (i == len - 1);
      rdret_q.push_back(r);
    end
  endtask

  task automatic wr_request(input logic [ADDR_BITS-1:0] addr, input logic [BURST_BITS:0] len);
    int n = 0;
    bus.wr_burst_addr = addr; bus.wr_burst_len = len; bus.wr_burst_req = 1'b1;
    do begin @(negedge mem_clk); n++; end while (!bus.wr_burst_ack && n < ACK_TIMEOUT);
    if (!bus.wr_burst_ack) begin
      checks++; failures++;
      $display("FAIL wr_ack_timeout actual=no_ack required=ack addr=%h", addr);
    end
    @(posedge mem_clk); #1;
    bus.wr_burst_req = 1'b0;
  endtask

  task automatic rd_request(input logic [ADDR_BITS-1:0] addr, input logic [BURST_BITS:0] len);
    int n = 0;
    bus.rd_burst_addr = addr; bus.rd_burst_len = len; bus.rd_burst_req = 1'b1;
    do begin @(negedge mem_clk); n++; end while (!bus.rd_burst_ack && n < ACK_TIMEOUT);
    if (!bus.rd_burst_ack) begin
      checks++; failures++;
      $display("FAIL rd_ack_timeout actual=no_ack required=ack addr=%h", addr);
    end
    @(posedge mem_clk); #1;
    bus.rd_burst_req = 1'b0;
  endtask

  function automatic int pending();
    return grant_q.size() + wr_q.size() + rdcmd_q.size() + rdret_q.size();
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() != 0 && n < DRAIN_TIMEOUT) begin @(posedge mem_clk); #1; n++; end
    checks++;
    if (pending() != 0) begin
      failures++;
      $display("FAIL %s_drain actual_pending=%0d required=0", name, pending());
    end
    repeat (4) @(posedge mem_clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    logic [255:0] v;
    v = '0;
    v = {bus.wr_burst_ack, bus.wr_data_req, bus.wr_burst_finish, bus.rd_burst_ack,
         bus.rd_data_valid, bus.rd_burst_data, bus.rd_burst_finish, bus.App_wr_en,
         bus.App_wr_addr, bus.App_wr_din, bus.App_wr_dm, bus.App_rd_en, bus.App_rd_addr};
    checks++;
    if (v != '0) begin
      failures++;
      $display("FAIL %s actual=%h required=0", name, v);
    end
  endtask

  // show-ahead write source: a pop seen in a cycle advances the word after that edge
  logic src_pop;
  initial begin
    bus.wr_burst_data = wr_word(0);
    forever begin
      @(negedge mem_clk); src_pop = bus.wr_data_req;
      @(posedge mem_clk); #1;
      if (src_pop) begin wr_pop_idx++; bus.wr_burst_data = wr_word(wr_pop_idx); end
    end
  end

  // controller read model: data returns 5 cycles after each command
  pend_t pend_new;
  always @(negedge mem_clk) begin
    if (!rst && bus.App_rd_en) begin
      pend_new.addr = bus.App_rd_addr; pend_new.due = cyc + 5;
      pend_q.push_back(pend_new);
    end
  end

  initial begin
    bus.Sdr_rd_en = 1'b0; bus.Sdr_rd_dout = '0;
    forever begin
      @(posedge mem_clk); #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.Sdr_rd_en = 1'b1; bus.Sdr_rd_dout = rd_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.Sdr_rd_en = 1'b0;
      end
    end
  end

  // scoreboard monitor
  grant_t mg; wr_exp_t mw; rd_ret_t mr; logic [ADDR_BITS-1:0] ma;
  logic exp_wf, exp_rf;
  always @(negedge mem_clk) begin
    if (!rst) begin
      exp_wf = 1'b0; exp_rf = 1'b0;
      if (bus.wr_burst_ack || bus.rd_burst_ack) begin
        ack_seen++; checks++;
        if (grant_q.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected actual wr_ack=%0b rd_ack=%0b required=none",
                   bus.wr_burst_ack, bus.rd_burst_ack);
        end else begin
          mg = grant_q.pop_front();
          if (bus.wr_burst_ack != !mg.is_rd || bus.rd_burst_ack != mg.is_rd) begin
            failures++;
            $display("FAIL grant_channel actual wr_ack=%0b rd_ack=%0b required rd=%0b",
                     bus.wr_burst_ack, bus.rd_burst_ack, mg.is_rd);
          end
          exp_wf = mg.len0 && !mg.is_rd;
          exp_rf = mg.len0 && mg.is_rd;
        end
      end
      if (bus.App_wr_en) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_cmd_unexpected actual addr=%h required=none", bus.App_wr_addr);
        end else begin
          mw = wr_q.pop_front();
          if (bus.App_wr_addr != mw.addr || bus.App_wr_din != mw.data) begin
            failures++;
            $display("FAIL wr_cmd actual addr=%h data=%h required addr=%h data=%h",
                     bus.App_wr_addr, bus.App_wr_din, mw.addr, mw.data);
          end
          exp_wf = exp_wf | mw.fin;
          if (mw.gap) begin
            checks++;
            if (cyc - last_wr_cyc != 2) begin
              failures++;
              $display("FAIL wr_cmd_spacing actual=%0d required=2", cyc - last_wr_cyc);
            end
          end
        end
        last_wr_cyc = cyc;
      end
      if (bus.App_rd_en) begin
        checks++;
        if (rdcmd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_cmd_unexpected actual addr=%h required=none", bus.App_rd_addr);
        end else begin
          ma = rdcmd_q.pop_front();
          if (bus.App_rd_addr != ma) begin
            failures++;
            $display("FAIL rd_cmd actual addr=%h required addr=%h", bus.App_rd_addr, ma);
          end
        end
      end
      if (bus.rd_data_valid) begin
        checks++;
        if (rdret_q.size() == 0) begin
          failures++;
          $display("FAIL rd_ret_unexpected actual data=%h required=none", bus.rd_burst_data);
        end else begin
          mr = rdret_q.pop_front();
          if (bus.rd_burst_data != mr.data) begin
            failures++;
            $display("FAIL rd_ret actual data=%h required data=%h", bus.rd_burst_data, mr.data);
          end
          exp_rf = exp_rf | mr.fin;
        end
      end
      if (exp_wf || bus.wr_burst_finish) begin
        checks++;
        if (bus.wr_burst_finish != exp_wf) begin
          failures++;
          $display("FAIL wr_finish actual=%0b required=%0b", bus.wr_burst_finish, exp_wf);
        end
      end
      if (exp_rf || bus.rd_burst_finish) begin
        checks++;
        if (bus.rd_burst_finish != exp_rf) begin
          failures++;
          $display("FAIL rd_finish actual=%0b required=%0b", bus.rd_burst_finish, exp_rf);
        end
      end
      if (bus.Sdr_busy) begin
        checks++;
        if (bus.wr_data_req || (busy_prev && bus.App_wr_en)) begin
          failures++;
          $display("FAIL busy_hold actual wr_data_req=%0b App_wr_en=%0b required=0 0",
                   bus.wr_data_req, bus.App_wr_en);
        end
      end
      busy_prev = bus.Sdr_busy;
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  int n;
  initial begin
    rst = 1'b1;
    bus.Sdr_init_done = 1'b0; bus.Sdr_busy = 1'b0; bus.rd_urgent = 1'b0;
    bus.wr_burst_req = 1'b0; bus.wr_burst_addr = '0; bus.wr_burst_len = '0;
    bus.rd_burst_req = 1'b0; bus.rd_burst_addr = '0; bus.rd_burst_len = '0;
    repeat (3) @(posedge mem_clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;
    @(posedge mem_clk); #1;
    check_zero("post_reset_outputs");

    // init gating, then first tie goes to write
    fork
      wr_request(21'h000100, 11'd1);
      rd_request(21'h000200, 11'd1);
      begin
        repeat (100) @(posedge mem_clk);
        #1;
        checks++;
        if (ack_seen != 0) begin
          failures++;
          $display("FAIL ack_before_init actual=%0d required=0", ack_seen);
        end
        push_wr(21'h000100, 1, 1'b0);
        push_rd(21'h000200, 1);
        bus.Sdr_init_done = 1'b1;
      end
    join
    wait_drain("init_tie");

    // address wrap at the top of the space, one strobe every second cycle
    push_wr(21'h1FFFFE, 4, 1'b1);
    wr_request(21'h1FFFFE, 11'd4);
    wait_drain("wr_wrap");

    // read with delayed returns
    push_rd(21'h000400, 3);
    rd_request(21'h000400, 11'd3);
    wait_drain("rd_len3");

    // both held: W,R,W,R
    push_wr(21'h000010, 2, 1'b0);
    push_rd(21'h000020, 2);
    push_wr(21'h000030, 2, 1'b0);
    push_rd(21'h000040, 2);
    fork
      begin wr_request(21'h000010, 11'd2); wr_request(21'h000030, 11'd2); end
      begin rd_request(21'h000020, 11'd2); rd_request(21'h000040, 11'd2); end
    join
    wait_drain("round_robin");

    // urgent read wins twice in a row over a waiting write
    bus.rd_urgent = 1'b1;
    push_rd(21'h000050, 1);
    push_rd(21'h000060, 1);
    push_wr(21'h000070, 1, 1'b0);
    fork
      wr_request(21'h000070, 11'd1);
      begin rd_request(21'h000050, 11'd1); rd_request(21'h000060, 11'd1); end
    join
    bus.rd_urgent = 1'b0;
    wait_drain("urgent");

    // controller busy mid write burst
    push_wr(21'h000800, 6, 1'b0);
    fork
      wr_request(21'h000800, 11'd6);
      begin
        n = 0;
        while (wr_q.size() > 4 && n < 500) begin @(posedge mem_clk); #1; n++; end
        bus.Sdr_busy = 1'b1;
        repeat (10) @(posedge mem_clk);
        #1;
        bus.Sdr_busy = 1'b0;
      end
    join
    wait_drain("busy_stall");

    // asynchronous reset in the middle of a read burst
    push_rd(21'h000300, 8);
    rd_request(21'h000300, 11'd8);
    n = 0;
    while (rdret_q.size() > 6 && n < 1000) begin @(posedge mem_clk); #1; n++; end
    checks++;
    if (rdret_q.size() > 6) begin
      failures++;
      $display("FAIL rd_before_reset actual_pending=%0d required<=6", rdret_q.size());
    end
    @(posedge mem_clk); #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset_outputs");
    grant_q.delete(); rdcmd_q.delete(); rdret_q.delete(); pend_q.delete();
    repeat (2) @(posedge mem_clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge mem_clk);
    #1;

    // zero-length bursts: ack and finish together, no commands
    push_wr(21'h000900, 0, 1'b0);
    wr_request(21'h000900, 11'd0);
    wait_drain("wr_len0");
    push_rd(21'h000A00, 0);
    rd_request(21'h000A00, 11'd0);
    wait_drain("rd_len0");

    repeat (20) @(posedge mem_clk);
    #1;
    checks++;
    if (pending() != 0 || pend_q.size() != 0) begin
      failures++;
      $display("FAIL leftover actual_pending=%0d required=0", pending() + pend_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
